// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - register map, modes, FSM states and saturation helpers for the PID engine
// Purpose : shared definitions imported by pid_mul_sat and pid_controller_mux.
// Ports   : none (package).
package pid_pkg;

  // Arithmetic is carried in 64 bits so that, for W up to 32, full products,
  // W+1 bit differences and W+3 bit sums are exact before saturation.
  typedef logic signed [63:0] wide_t;

  localparam logic [3:0] ADDR_KP       = 4'd0;
  localparam logic [3:0] ADDR_KI       = 4'd1;
  localparam logic [3:0] ADDR_KD       = 4'd2;
  localparam logic [3:0] ADDR_KFF      = 4'd3;
  localparam logic [3:0] ADDR_SP       = 4'd4;
  localparam logic [3:0] ADDR_OUT_POS  = 4'd5;
  localparam logic [3:0] ADDR_OUT_NEG  = 4'd6;
  localparam logic [3:0] ADDR_INT_POS  = 4'd7;
  localparam logic [3:0] ADDR_INT_NEG  = 4'd8;
  localparam logic [3:0] ADDR_DEAD     = 4'd9;
  localparam logic [3:0] ADDR_MODE     = 4'd10;

  localparam logic [1:0] MODE_POS  = 2'd0;
  localparam logic [1:0] MODE_VEL  = 2'd1;
  localparam logic [1:0] MODE_DISP = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ERR,
    ST_MUL_P,
    ST_MUL_I,
    ST_MUL_D,
    ST_MUL_FF,
    ST_SUM,
    ST_DONE
  } pid_state_t;

  // Saturate x to the range of a w-bit signed number.
  function automatic wide_t sat(input wide_t x, input int w);
    wide_t hi;
    wide_t lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Lower bound is applied first, so an inverted pair (lo > hi) resolves to hi.
  function automatic wide_t clamp(input wide_t x, input wide_t lo, input wide_t hi);
    wide_t y;
    y = (x < lo) ? lo : x;
    return (y > hi) ? hi : y;
  endfunction

endpackage

// File: rtl/pid_mul_sat.sv
// rtl/pid_mul_sat.sv - shared signed multiplier with fractional shift and saturation
// Purpose : p = sat_W((a * b) >>> FRAC); full 2W-bit product before the shift.
// Ports   : a, b - signed W-bit operands; p - saturated signed W-bit product.
// Purely combinational; the parent registers p.
module pid_mul_sat
  import pid_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 0
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  logic signed [2*W-1:0] prod;

  always_comb begin
    prod = (2*W)'(a) * (2*W)'(b);
    p    = W'(sat(wide_t'(prod >>> FRAC), W));
  end

endmodule

// File: rtl/pid_controller_mux.sv
// rtl/pid_controller_mux.sv - time-multiplexed PID engine for CHANNELS channels on one multiplier
// Purpose : on each controller_update rising edge, sweep channels 0..CHANNELS-1 computing
//           P, I (anti-windup), D and feed-forward terms with saturating arithmetic.
// Ports   : clock, reset (async, active-high)
//           cfg_we/cfg_ch/cfg_addr/cfg_data - per-channel register writes
//           position/velocity/displacement   - flattened feedback, lane c at [c*W +: W]
//           controller_update                - rising edge starts a sweep
//           result                           - registered per-channel outputs
//           busy/done/overrun                - sweep status (overrun is sticky)
// W must not exceed 32 (internal arithmetic is 64 bits wide).
module pid_controller_mux
  import pid_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int W        = 32,
  parameter int FRAC     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_ch,
  input  logic [3:0]            cfg_addr,
  input  logic [W-1:0]          cfg_data,
  input  logic [CHANNELS*W-1:0] position,
  input  logic [CHANNELS*W-1:0] velocity,
  input  logic [CHANNELS*W-1:0] displacement,
  input  logic                  controller_update,
  output logic [CHANNELS*W-1:0] result,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Per-channel register file
  logic signed [W-1:0] kp_r      [CHANNELS];
  logic signed [W-1:0] ki_r      [CHANNELS];
  logic signed [W-1:0] kd_r      [CHANNELS];
  logic signed [W-1:0] kff_r     [CHANNELS];
  logic signed [W-1:0] sp_r      [CHANNELS];
  logic signed [W-1:0] out_pos_r [CHANNELS];
  logic signed [W-1:0] out_neg_r [CHANNELS];
  logic signed [W-1:0] int_pos_r [CHANNELS];
  logic signed [W-1:0] int_neg_r [CHANNELS];
  logic signed [W-1:0] dead_r    [CHANNELS];
  logic [1:0]          mode_r    [CHANNELS];

  // Per-channel controller state
  logic signed [W-1:0] integ_r   [CHANNELS];
  logic signed [W-1:0] last_r    [CHANNELS];

  // Working copy of the channel being processed, captured in LOAD
  logic signed [W-1:0] l_kp, l_ki, l_kd, l_kff, l_sp;
  logic signed [W-1:0] l_opos, l_oneg, l_ipos, l_ineg, l_dead;
  logic signed [W-1:0] l_pv, l_int, l_last;
  logic [1:0]          l_mode;

  logic signed [W-1:0] err, derr, pterm, iinc, dterm, ffterm;

  pid_state_t          state;
  logic [CH_W-1:0]     ch;
  logic                upd_cur, upd_prev;
  logic                start;

  logic [CH_W-1:0]     cfg_idx;
  logic signed [W-1:0] fb_sel;
  logic signed [W-1:0] mul_a, mul_b, mul_p;
  logic signed [W-1:0] err_c, derr_c;
  logic signed [W-1:0] int_upd, int_new, sum_res;
  logic signed [W-1:0] res_n, int_n, last_n;
  logic                in_dead, p_ok;

  assign start   = upd_cur & ~upd_prev;
  assign cfg_idx = cfg_ch[CH_W-1:0];

  // Register file writes; out-of-range channels and addresses 11..15 are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        kp_r[c]      <= '0;
        ki_r[c]      <= '0;
        kd_r[c]      <= '0;
        kff_r[c]     <= '0;
        sp_r[c]      <= '0;
        out_pos_r[c] <= '0;
        out_neg_r[c] <= '0;
        int_pos_r[c] <= '0;
        int_neg_r[c] <= '0;
        dead_r[c]    <= '0;
        mode_r[c]    <= '0;
      end
    end else if (cfg_we && (int'(cfg_ch) < CHANNELS)) begin
      case (cfg_addr)
        ADDR_KP:      kp_r[cfg_idx]      <= cfg_data;
        ADDR_KI:      ki_r[cfg_idx]      <= cfg_data;
        ADDR_KD:      kd_r[cfg_idx]      <= cfg_data;
        ADDR_KFF:     kff_r[cfg_idx]     <= cfg_data;
        ADDR_SP:      sp_r[cfg_idx]      <= cfg_data;
        ADDR_OUT_POS: out_pos_r[cfg_idx] <= cfg_data;
        ADDR_OUT_NEG: out_neg_r[cfg_idx] <= cfg_data;
        ADDR_INT_POS: int_pos_r[cfg_idx] <= cfg_data;
        ADDR_INT_NEG: int_neg_r[cfg_idx] <= cfg_data;
        ADDR_DEAD:    dead_r[cfg_idx]    <= cfg_data;
        ADDR_MODE:    mode_r[cfg_idx]    <= cfg_data[1:0];
        default: ;
      endcase
    end
  end

  // Feedback lane for the current channel, chosen by its mode
  always_comb begin
    fb_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(ch) == c) begin
        case (mode_r[c])
          MODE_POS:  fb_sel = position[c*W +: W];
          MODE_VEL:  fb_sel = velocity[c*W +: W];
          MODE_DISP: fb_sel = displacement[c*W +: W];
          default:   fb_sel = '0;
        endcase
      end
    end
  end

  // Operand steering for the single shared multiplier
  always_comb begin
    mul_a = l_kp;
    mul_b = err;
    case (state)
      ST_MUL_I:  mul_a = l_ki;
      ST_MUL_D:  begin mul_a = l_kd;  mul_b = derr; end
      ST_MUL_FF: begin mul_a = l_kff; mul_b = l_sp; end
      default: ;
    endcase
  end

  pid_mul_sat #(.W(W), .FRAC(FRAC)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Error terms and the SUM-cycle update of result / integral / lastError
  always_comb begin
    err_c   = W'(sat(wide_t'(l_sp) - wide_t'(l_pv), W));
    derr_c  = W'(sat(wide_t'(err_c) - wide_t'(l_last), W));

    in_dead = (wide_t'(err) >= -wide_t'(l_dead)) && (wide_t'(err) <= wide_t'(l_dead));
    // Anti-windup: the integral only moves while P alone stays inside the output range.
    p_ok    = (pterm > l_oneg) && (pterm < l_opos);
    int_upd = W'(clamp(sat(wide_t'(l_int) + wide_t'(iinc), W),
                       wide_t'(l_ineg), wide_t'(l_ipos)));
    int_new = p_ok ? int_upd : l_int;
    sum_res = W'(clamp(wide_t'(ffterm) + wide_t'(pterm) + wide_t'(int_new) + wide_t'(dterm),
                       wide_t'(l_oneg), wide_t'(l_opos)));

    if (l_mode == MODE_OFF) begin
      res_n  = '0;
      int_n  = '0;
      last_n = '0;
    end else if (in_dead) begin
      res_n  = l_int;
      int_n  = l_int;
      last_n = err;
    end else begin
      res_n  = sum_res;
      int_n  = int_new;
      last_n = err;
    end
  end

  // Sweep sequencer: 7 cycles per channel, then DONE for the done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ch       <= '0;
      upd_cur  <= 1'b0;
      upd_prev <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      result   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        integ_r[c] <= '0;
        last_r[c]  <= '0;
      end
      l_kp   <= '0; l_ki   <= '0; l_kd   <= '0; l_kff  <= '0; l_sp   <= '0;
      l_opos <= '0; l_oneg <= '0; l_ipos <= '0; l_ineg <= '0; l_dead <= '0;
      l_pv   <= '0; l_int  <= '0; l_last <= '0; l_mode <= '0;
      err    <= '0; derr   <= '0;
      pterm  <= '0; iinc   <= '0; dterm  <= '0; ffterm <= '0;
    end else begin
      upd_cur  <= controller_update;
      upd_prev <= upd_cur;
      done     <= 1'b0;
      if (start && (state != ST_IDLE)) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
            ch    <= '0;
          end
        end
        ST_LOAD: begin
          l_kp   <= kp_r[ch];
          l_ki   <= ki_r[ch];
          l_kd   <= kd_r[ch];
          l_kff  <= kff_r[ch];
          l_sp   <= sp_r[ch];
          l_opos <= out_pos_r[ch];
          l_oneg <= out_neg_r[ch];
          l_ipos <= int_pos_r[ch];
          l_ineg <= int_neg_r[ch];
          l_dead <= dead_r[ch];
          l_mode <= mode_r[ch];
          l_pv   <= fb_sel;
          l_int  <= integ_r[ch];
          l_last <= last_r[ch];
          state  <= ST_ERR;
        end
        ST_ERR: begin
          err   <= err_c;
          derr  <= derr_c;
          state <= ST_MUL_P;
        end
        ST_MUL_P:  begin pterm  <= mul_p; state <= ST_MUL_I;  end
        ST_MUL_I:  begin iinc   <= mul_p; state <= ST_MUL_D;  end
        ST_MUL_D:  begin dterm  <= mul_p; state <= ST_MUL_FF; end
        ST_MUL_FF: begin ffterm <= mul_p; state <= ST_SUM;    end
        ST_SUM: begin
          integ_r[ch] <= int_n;
          last_r[ch]  <= last_n;
          for (int c = 0; c < CHANNELS; c++) begin
            if (int'(ch) == c) result[c*W +: W] <= res_n;
          end
          if (ch == CH_W'(CHANNELS - 1)) begin
            state <= ST_DONE;
          end else begin
            ch    <= ch + 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_controller_mux.sv
// tb/tb_pid_controller_mux.sv - directed self-checking bench for pid_controller_mux
module tb_pid_controller_mux;

  localparam int CH = 6;
  localparam int W  = 32;
  localparam int SW = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic            cfg_we;
  logic [3:0]      cfg_ch, cfg_addr;
  logic [W-1:0]    cfg_data;
  logic [CH*W-1:0] position, velocity, displacement, result;
  logic            controller_update, busy, done, overrun;

  logic            s_cfg_we;
  logic [3:0]      s_cfg_ch, s_cfg_addr;
  logic [SW-1:0]   s_cfg_data, s_position, s_velocity, s_displacement, s_result;
  logic            s_update, s_busy, s_done, s_overrun;

  int checks = 0;
  int errors = 0;

  pid_controller_mux #(.CHANNELS(CH), .W(W), .FRAC(0)) dut (
    .clock (clock), .reset (reset),
    .cfg_we (cfg_we), .cfg_ch (cfg_ch), .cfg_addr (cfg_addr), .cfg_data (cfg_data),
    .position (position), .velocity (velocity), .displacement (displacement),
    .controller_update (controller_update),
    .result (result), .busy (busy), .done (done), .overrun (overrun)
  );

  pid_controller_mux #(.CHANNELS(1), .W(SW), .FRAC(8)) dut_small (
    .clock (clock), .reset (reset),
    .cfg_we (s_cfg_we), .cfg_ch (s_cfg_ch), .cfg_addr (s_cfg_addr), .cfg_data (s_cfg_data),
    .position (s_position), .velocity (s_velocity), .displacement (s_displacement),
    .controller_update (s_update),
    .result (s_result), .busy (s_busy), .done (s_done), .overrun (s_overrun)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lane(input int c);
    return longint'($signed(result[c*W +: W]));
  endfunction

  task automatic wr(input int ch, input int addr, input longint data);
    @(negedge clock);
    cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_addr = 4'(addr); cfg_data = W'(data);
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic s_wr(input int ch, input int addr, input longint data);
    @(negedge clock);
    s_cfg_we = 1'b1; s_cfg_ch = 4'(ch); s_cfg_addr = 4'(addr); s_cfg_data = SW'(data);
    @(negedge clock);
    s_cfg_we = 1'b0;
  endtask

  // One update pulse; done is expected 2 edges (input register + edge detect)
  // plus 7*CH+1 edges after the update input rises.
  task automatic sweep(input string tag);
    int n;
    @(negedge clock);
    controller_update = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!done && n < 200);
    check({tag, "_latency"}, n, 7*CH + 3);
    @(negedge clock);
    check({tag, "_done_pulse"}, done, 0);
    controller_update = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic s_sweep(input string tag);
    int n;
    @(negedge clock);
    s_update = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!s_done && n < 200);
    check({tag, "_latency"}, n, 7*1 + 3);
    s_update = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int ndone;
    reset = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
    position = '0; velocity = '0; displacement = '0; controller_update = 1'b0;
    s_cfg_we = 1'b0; s_cfg_ch = '0; s_cfg_addr = '0; s_cfg_data = '0;
    s_position = '0; s_velocity = '0; s_displacement = '0; s_update = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int c = 0; c < CH; c++) check($sformatf("reset_result%0d", c), lane(c), 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_overrun", overrun, 0);

    // ch0: plain P; ch1: pure I with clamp; ch2: I then deadband;
    // ch3: D + feed-forward; ch4: velocity feedback; ch5: disabled.
    position[0*W +: W] = 40;
    velocity[4*W +: W] = -7;
    wr(0, 0, 2);   wr(0, 4, 100); wr(0, 5, 1000); wr(0, 6, -1000);
    wr(1, 1, 1);   wr(1, 4, 100); wr(1, 5, 1000); wr(1, 6, -1000); wr(1, 7, 250); wr(1, 8, -250);
    wr(2, 1, 1);   wr(2, 4, 30);  wr(2, 5, 1000); wr(2, 6, -1000); wr(2, 7, 1000); wr(2, 8, -1000);
    wr(3, 2, 1);   wr(3, 3, 3);   wr(3, 4, 100);  wr(3, 5, 1000);  wr(3, 6, -1000);
    wr(4, 10, 1);  wr(4, 0, 1);   wr(4, 5, 1000); wr(4, 6, -1000);
    wr(5, 10, 3);  wr(5, 0, 1);   wr(5, 4, 9);    wr(5, 5, 1000);  wr(5, 6, -1000);

    sweep("s1");
    check("s1_ch0_p", lane(0), 120);
    check("s1_ch1_i", lane(1), 100);
    check("s1_ch2_i", lane(2), 30);
    check("s1_ch3_ff_d", lane(3), 400);
    check("s1_ch4_vel", lane(4), 7);
    check("s1_ch5_off", lane(5), 0);
    check("s1_busy_after", busy, 0);

    wr(2, 9, 5); wr(2, 4, 5);       // err=5 sits on the deadband edge
    wr(4, 6, 500); wr(4, 5, 100);   // inverted output limits
    wr(8, 0, 7);                    // channel 8 does not exist
    sweep("s2");
    check("s2_ch0_badch_ignored", lane(0), 120);
    check("s2_ch1_i", lane(1), 200);
    check("s2_ch2_deadband", lane(2), 30);
    check("s2_ch3_d_zero", lane(3), 300);
    check("s2_ch4_inverted_lim", lane(4), 100);

    wr(2, 4, -6);                   // err=-6 just outside deadband
    sweep("s3");
    check("s3_ch1_int_clamp", lane(1), 250);
    check("s3_ch2_outside_db", lane(2), 24);

    wr(1, 7, 1000); wr(1, 0, 100); wr(1, 4, 50);
    sweep("s4");
    check("s4_ch1_out_clamp", lane(1), 1000);

    wr(1, 0, 0); wr(1, 1, 0);
    sweep("s5");
    check("s5_ch1_antiwindup", lane(1), 250);
    check("s5_overrun_clear", overrun, 0);

    // Second rising edge while busy
    @(negedge clock);
    controller_update = 1'b1;
    repeat (10) @(negedge clock);
    controller_update = 1'b0;
    repeat (2) @(negedge clock);
    controller_update = 1'b1;
    ndone = 0;
    repeat (80) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("ovr_overrun", overrun, 1);
    check("ovr_single_done", ndone, 1);
    check("ovr_busy_end", busy, 0);
    controller_update = 1'b0;
    repeat (2) @(negedge clock);

    // Narrow build: saturation on the multiplier and fractional gain
    s_wr(0, 0, 16'h7FFF); s_wr(0, 4, 16'h7FFF); s_wr(0, 5, 16'h7FFF); s_wr(0, 6, 16'h8000);
    s_sweep("n1");
    check("n1_p_saturates", longint'($signed(s_result)), 32767);
    s_wr(0, 0, 16'h0180); s_wr(0, 4, 100); s_wr(0, 5, 1000); s_wr(0, 6, -1000);
    s_wr(1, 0, 16'h7FFF);           // channel 1 does not exist in this build
    s_sweep("n2");
    check("n2_frac_gain", longint'($signed(s_result)), 150);

    // Reset in the middle of a sweep
    @(negedge clock);
    controller_update = 1'b1;
    repeat (20) @(negedge clock);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    controller_update = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("rst_no_done", ndone, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    for (int c = 0; c < CH; c++) check($sformatf("rst_result%0d", c), lane(c), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
